// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access sequencer.
package lc3_mem_pkg;

  localparam int unsigned DefaultWaitStates = 2;
  localparam int unsigned CntWidth          = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StAck
  } mem_state_e;

endpackage

// File: rtl/reg_16.sv
// 16-bit load-enabled register with synchronous active-high clear.
module reg_16 (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic [15:0] D,
  output logic [15:0] Data_Out
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Data_Out <= 16'h0000;
    end else if (Load) begin
      Data_Out <= D;
    end
  end

endmodule

// File: rtl/mem_sequencer.sv
// Sequences one SRAM read or write per four-phase request from the control unit,
// stretching each access by WAIT_STATES extra cycles.
module mem_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = DefaultWaitStates
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic        Req_Read,
  input  logic        Req_Write,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] Mem_Data_In,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_Data_Out,
  output logic        Data_Drive,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic        Busy
);

  localparam logic [CntWidth-1:0] WaitInit = CntWidth'(WAIT_STATES);

  mem_state_e          r_state, w_state_next;
  logic [CntWidth-1:0] r_cnt, w_cnt_next;
  logic                w_start;
  logic                w_capture;

  // Latches load only on the IDLE exit edge, so later MAR/MDR changes are ignored.
  assign w_start   = (r_state == StIdle) && (Req_Read || Req_Write);
  assign w_capture = (r_state == StRead) && (r_cnt == '0);

  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StIdle: begin
        if (Req_Read) begin
          w_state_next = StRead;
          w_cnt_next   = WaitInit;
        end else if (Req_Write) begin
          w_state_next = StWrite;
          w_cnt_next   = WaitInit;
        end
      end
      StRead, StWrite: begin
        if (r_cnt == '0) begin
          w_state_next = StAck;
        end else begin
          w_cnt_next = r_cnt - CntWidth'(1);
        end
      end
      StAck: begin
        // Wait for the request to drop so one request yields exactly one access.
        if (!Req_Read && !Req_Write) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    Mem_CE     = 1'b1;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    Data_Drive = 1'b0;
    unique case (r_state)
      StRead: begin
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
      end
      StWrite: begin
        Mem_CE     = 1'b0;
        Mem_WE     = 1'b0;
        Data_Drive = 1'b1;
      end
      default: ;
    endcase
  end

  assign R    = (r_state == StAck);
  assign Busy = (r_state != StIdle);

  reg_16 u_addr_reg (
    .Clk      (Clk),
    .Reset    (Reset_ah),
    .Load     (w_start),
    .D        (MAR),
    .Data_Out (Mem_Addr)
  );

  reg_16 u_wdata_reg (
    .Clk      (Clk),
    .Reset    (Reset_ah),
    .Load     (w_start),
    .D        (MDR),
    .Data_Out (Mem_Data_Out)
  );

  reg_16 u_rdata_reg (
    .Clk      (Clk),
    .Reset    (Reset_ah),
    .Load     (w_capture),
    .D        (Mem_Data_In),
    .Data_Out (MDR_In)
  );

endmodule

// File: tb/tb_mem_sequencer.sv
// Two sequencers (WAIT_STATES=2 and 0) share stimulus; each talks to its own SRAM model
// and is checked against a transaction-level golden memory.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wr;
  logic [15:0] mar, mdr;
  logic [15:0] din    [2];
  logic [15:0] addr   [2];
  logic [15:0] dout   [2];
  logic [15:0] mdr_in [2];
  logic        drv [2], ce [2], oe [2], we [2], r [2], busy [2];

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] mem0 [65536];
  logic [15:0] mem1 [65536];
  logic [15:0] gold [65536];
  logic [15:0] last_rd [2];

  int          rd_cyc [2], wr_cyc [2], r_cyc [2], viol [2];
  logic [15:0] exp_addr, exp_data;

  always #5 clk = ~clk;

  mem_sequencer #(.WAIT_STATES(2)) u_dut_ws2 (
    .Clk(clk), .Reset_ah(rst), .Req_Read(req_rd), .Req_Write(req_wr), .MAR(mar), .MDR(mdr),
    .Mem_Data_In(din[0]), .Mem_Addr(addr[0]), .Mem_Data_Out(dout[0]), .Data_Drive(drv[0]),
    .Mem_CE(ce[0]), .Mem_OE(oe[0]), .Mem_WE(we[0]), .MDR_In(mdr_in[0]), .R(r[0]),
    .Busy(busy[0])
  );

  mem_sequencer #(.WAIT_STATES(0)) u_dut_ws0 (
    .Clk(clk), .Reset_ah(rst), .Req_Read(req_rd), .Req_Write(req_wr), .MAR(mar), .MDR(mdr),
    .Mem_Data_In(din[1]), .Mem_Addr(addr[1]), .Mem_Data_Out(dout[1]), .Data_Drive(drv[1]),
    .Mem_CE(ce[1]), .Mem_OE(oe[1]), .Mem_WE(we[1]), .MDR_In(mdr_in[1]), .R(r[1]),
    .Busy(busy[1])
  );

  function automatic int ws_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // SRAM models and bus monitors, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!ce[i] && !oe[i]) rd_cyc[i]++;
      if (!ce[i] && !we[i]) begin
        wr_cyc[i]++;
        if (drv[i]) begin
          if (i == 0) mem0[addr[i]] = dout[i];
          else        mem1[addr[i]] = dout[i];
        end
      end
      if (drv[i] && we[i]) viol[i]++;
      if (!ce[i] && (addr[i] !== exp_addr)) viol[i]++;
      if (!ce[i] && !we[i] && (dout[i] !== exp_data)) viol[i]++;
      if (r[i]) r_cyc[i]++;
      din[i] = (i == 0) ? mem0[addr[i]] : mem1[addr[i]];
    end
  end

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq({tag, "_r"},    r[i],    1'b0);
      check_eq({tag, "_busy"}, busy[i], 1'b0);
      check_eq({tag, "_strb"}, {ce[i], oe[i], we[i], drv[i]}, 4'b1110);
    end
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [15:0] a,
                           input logic [15:0] d, input bit scramble, input bit drop,
                           input int hold, input string tag);
    int lat [2];
    bit done [2];
    bit is_rd;
    is_rd = rd;
    @(posedge clk); #1;
    req_rd = rd; req_wr = wr; mar = a; mdr = d;
    exp_addr = a; exp_data = d;
    for (int i = 0; i < 2; i++) begin
      rd_cyc[i] = 0; wr_cyc[i] = 0; r_cyc[i] = 0; viol[i] = 0;
      lat[i] = 0; done[i] = 1'b0;
    end
    for (int c = 1; c <= 40 && !(done[0] && done[1]); c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        if (scramble) begin
          mar = 16'($urandom);
          mdr = 16'h0000;
        end
        if (drop) begin
          req_rd = 1'b0;
          req_wr = 1'b0;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (!done[i] && r[i]) begin
          done[i] = 1'b1;
          lat[i]  = c;
        end
      end
    end
    for (int i = 0; i < 2; i++) check_eq({tag, "_lat"}, lat[i], ws_of(i) + 2);
    if (!drop) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) check_eq({tag, "_hold_r"}, {r[i], busy[i]}, 2'b11);
      end
      req_rd = 1'b0;
      req_wr = 1'b0;
    end
    @(posedge clk); #1;
    check_idle({tag, "_end"});
    for (int i = 0; i < 2; i++) begin
      if (drop) check_eq({tag, "_ack1"}, r_cyc[i], 1);
      check_eq({tag, "_rdcyc"}, rd_cyc[i], is_rd ? ws_of(i) + 1 : 0);
      check_eq({tag, "_wrcyc"}, wr_cyc[i], is_rd ? 0 : ws_of(i) + 1);
      check_eq({tag, "_bus"}, viol[i], 0);
      if (is_rd) last_rd[i] = gold[a];
      check_eq({tag, "_mdrin"}, mdr_in[i], last_rd[i]);
    end
    if (!is_rd) gold[a] = d;
  endtask

  initial begin
    for (int k = 0; k < 65536; k++) begin
      mem0[k] = ~16'(k);
      mem1[k] = ~16'(k);
      gold[k] = ~16'(k);
    end
    mem0[16'h3000] = 16'hBEEF;
    mem1[16'h3000] = 16'hBEEF;
    gold[16'h3000] = 16'hBEEF;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    exp_addr = 16'h0000;
    exp_data = 16'h0000;
    rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; mar = 16'h0000; mdr = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    for (int i = 0; i < 2; i++) begin
      check_eq("reset_regs", {addr[i], dout[i]}, 32'h0);
      check_eq("reset_mdrin", mdr_in[i], 16'h0000);
    end
    rst = 1'b0;

    do_access(1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 0, "rd_beef");
    do_access(1'b0, 1'b1, 16'h1234, 16'h5A5A, 1'b1, 1'b0, 0, "wr_scr");
    do_access(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 0, "rd_back");
    do_access(1'b1, 1'b1, 16'h3000, 16'hFFFF, 1'b0, 1'b0, 0, "both");
    do_access(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 5, "hold5");
    do_access(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 0, "b2b_1");
    do_access(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 0, "b2b_2");
    do_access(1'b0, 1'b1, 16'h0002, 16'hC0DE, 1'b0, 1'b1, 0, "wr_drop");
    do_access(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b1, 0, "rd_drop");

    // Reset during the second READ cycle of the WAIT_STATES=2 sequencer.
    @(posedge clk); #1;
    req_rd = 1'b1; mar = 16'h3000; exp_addr = 16'h3000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_mid_inread", {ce[0], oe[0]}, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_rd = 1'b0;
    check_idle("rst_mid");
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_mid_mdrin", mdr_in[i], 16'h0000);
      check_eq("rst_mid_addr", addr[i], 16'h0000);
      last_rd[i] = 16'h0000;
    end

    for (int t = 0; t < 24; t++) begin
      bit          rd, wr, scr, drp;
      logic [15:0] a, d;
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a   = 16'h0100 + 16'($urandom_range(0, 7));
      d   = 16'($urandom);
      scr = 1'($urandom_range(0, 1));
      drp = ($urandom_range(0, 3) == 0);
      do_access(rd, wr, a, d, scr, drp, int'($urandom_range(0, 3)), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter: WAIT_STATES, default 2, extra access cycles beyond the first; legal range 0..15.
REQ-002 Clk  in  1  single system clock; all state changes on posedge.
REQ-003 Reset_ah  in  1  synchronous, active-high reset.
REQ-004 Req_Read  in  1  level request from control unit: read memory at MAR.
REQ-005 Req_Write  in  1  level request from control unit: write MDR to memory at MAR.
REQ-006 MAR  in  16  datapath memory address register.
REQ-007 MDR  in  16  datapath memory data register (write data).
REQ-008 Mem_Data_In  in  16  data returned by SRAM.
REQ-009 Mem_Addr  out  16  latched address to SRAM.
REQ-010 Mem_Data_Out  out  16  latched write data to SRAM.
REQ-011 Data_Drive  out  1  1 = external tri-state drives Mem_Data_Out onto SRAM bus.
REQ-012 Mem_CE, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low.
REQ-013 MDR_In  out  16  captured read data, feeds datapath MDR input mux.
REQ-014 R  out  1  access-complete acknowledge (control unit polls it).
REQ-015 Busy  out  1  1 whenever state != IDLE.

Function
REQ-016 FSM states: IDLE, READ, WRITE, ACK.
REQ-017 IDLE: Req_Read=1 -> READ; else Req_Write=1 -> WRITE; else stay. Simultaneous requests: read wins.
REQ-018 On leaving IDLE, MAR latched into address register, MDR into write-data register, wait counter loaded with WAIT_STATES.
REQ-019 READ: Mem_CE=0, Mem_OE=0, Mem_WE=1; counter decrements each cycle; on the edge where counter==0, Mem_Data_In captured into MDR_In and state -> ACK.
REQ-020 WRITE: Mem_CE=0, Mem_WE=0, Mem_OE=1, Data_Drive=1; on the edge where counter==0, state -> ACK; MDR_In unchanged.
REQ-021 Access phase lasts exactly WAIT_STATES+1 cycles; a request sampled at edge k gives R=1 after edge k+WAIT_STATES+2.
REQ-022 ACK: R=1, all strobes high, Data_Drive=0; stay while Req_Read|Req_Write=1; -> IDLE on the first edge both are 0 (four-phase handshake, so one request causes exactly one access).
REQ-023 Outside READ/WRITE: Mem_CE=Mem_OE=Mem_WE=1, Data_Drive=0.
REQ-024 MAR/MDR/request changes during READ/WRITE are ignored; the access completes on latched values.
REQ-025 Request dropped mid-access: the access still completes; ACK lasts exactly one cycle.
REQ-026 MDR_In holds the last captured read value until the next read capture.
REQ-027 Mem_Addr and Mem_Data_Out always reflect the latch registers, not live MAR/MDR.
REQ-028 WAIT_STATES=0: single-cycle access, R=1 after edge k+2.

Reset
REQ-029 Reset_ah=1 at a posedge forces IDLE, counter=0, address/data/MDR_In registers=0x0000, R=0, Busy=0, all strobes 1, Data_Drive=0.
REQ-030 Reset overrides any state including mid-READ/WRITE; strobes deassert the cycle after the reset edge; no capture occurs on the reset edge.
REQ-031 Reset has priority over requests sampled on the same edge.

Structure
REQ-032 Shared package lc3_mem_pkg holds the state enum and the default WAIT_STATES constant.
REQ-033 Address, write-data and MDR_In latches reuse the existing reg_16 sub-module (Clk, Reset, Load, D, Data_Out).
REQ-034 FSM plus a 4-bit down-counter live in mem_sequencer; outputs decoded combinationally from state.

Verification
REQ-035 WAIT_STATES=2, MAR=0x3000, Mem_Data_In=0xBEEF, Req_Read pulse-held -> OE/CE low exactly 3 cycles, MDR_In=0xBEEF, R=1 after 4th edge.
REQ-036 Req_Write with MAR=0x1234, MDR=0x5A5A, MDR changed to 0 mid-access -> WE low 3 cycles, Mem_Addr=0x1234, Mem_Data_Out=0x5A5A throughout, Data_Drive=1 only during WRITE.
REQ-037 Req_Read and Req_Write both 1 in IDLE -> READ performed, no WE assertion.
REQ-038 Request held 5 cycles past R -> R stays 1, no second access; drop request -> IDLE next edge, Busy=0.
REQ-039 Reset_ah asserted during 2nd READ cycle -> next cycle IDLE, strobes high, MDR_In=0x0000, R=0.
REQ-040 WAIT_STATES=0 back-to-back reads 0x0001/0x0002 with handshake -> each R after 2 edges, MDR_In matches each address's data.
